router_dest_rx: RTL

Destination-side packet consumer for one router output port; it sits on the opposite end of the `vld_out`/`read_enb`/`soft_reset` handshake that the router's sync logic drives toward the destination.
- Watches `vld_out` and waits a programmed delay.
- Drains one complete packet from the port FIFO: header, payload and parity byte.
- Streams payload bytes downstream and reports length, address and parity status per packet.
- Used as the synthesizable destination model in system benches and as the front end of destination interfaces.

---
 rtl/router_pkg.sv | 41 ++++
 rtl/router_rx_parity.sv | 42 ++++
 rtl/router_dest_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router destination-side reader.
//   - rx_state_e       : reader FSM states
//   - HDR_* constants  : header byte field positions {len[5:0], addr[1:0]}
//   - MAX_PAYLOAD      : largest payload length a header can encode
//   - SOFT_RST_TIMEOUT : router flush window; bounds the legal READ_DELAY
//   - pkt_total()      : number of FIFO reads a packet needs
// ---------------------------------------------------------------------------
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    DRAIN,
    DONE
  } rx_state_e;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_ADDR_LSB = 0;
  localparam int LEN_W        = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  localparam int MAX_PAYLOAD      = 63;
  localparam int SOFT_RST_TIMEOUT = 30;
  // First read must land well inside the router flush window.
  localparam int MAX_READ_DELAY   = SOFT_RST_TIMEOUT - 5;

  // Wide enough to count header + MAX_PAYLOAD + parity without wrapping.
  localparam int CNT_W = $clog2(MAX_PAYLOAD + 3);

  // Reads needed for the packet: 2 until the header is known (header plus one
  // speculative read that is always legal), then len + 2.
  function automatic logic [CNT_W-1:0] pkt_total(input logic hdr_seen,
                                                 input logic [LEN_W-1:0] len);
    return hdr_seen ? CNT_W'(len) + CNT_W'(2) : CNT_W'(2);
  endfunction

endpackage

// File: rtl/router_rx_parity.sv
// ---------------------------------------------------------------------------
// router_rx_parity
// 8-bit XOR accumulator for packet parity checking.
//   clock_i    : clock, rising edge
//   resetn_i   : asynchronous active-low reset
//   init_i     : load accumulator with data_i (header byte seeds it)
//   acc_i      : XOR data_i into the accumulator
//   data_i     : byte being captured
//   mismatch_o : data_i differs from the accumulated parity (combinational)
// ---------------------------------------------------------------------------
module router_rx_parity (
  input  logic       clock_i,
  input  logic       resetn_i,
  input  logic       init_i,
  input  logic       acc_i,
  input  logic [7:0] data_i,
  output logic       mismatch_o
);

  logic [7:0] acc_q;
  logic [7:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (init_i) begin
      acc_d = data_i;
    end else if (acc_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign mismatch_o = (acc_q != data_i);

endmodule

// File: rtl/router_dest_rx.sv
// ---------------------------------------------------------------------------
// router_dest_rx
// Destination-side packet consumer for one router output port. Waits
// READ_DELAY cycles after vld_out, drains header/payload/parity from the port
// FIFO, streams payload bytes and reports per-packet status.
//
// Parameters: PORT_ADDR (expected header[1:0]), READ_DELAY (0..25)
// Inputs : clock, resetn (async, active low), vld_out, data_out[7:0],
//          soft_reset, hold
// Outputs: read_enb (combinational), byte_valid, byte_data[7:0], pkt_done,
//          pkt_abort, pkt_len[5:0], addr_err, parity_err (all registered)
//
// Build option: define ROUTER_DEST_PARITY_CHK_EN to include the parity
// accumulator; otherwise parity_err is tied to 0 (parity byte still consumed).
// ---------------------------------------------------------------------------
module router_dest_rx
  import router_pkg::*;
#(
  parameter logic [1:0] PORT_ADDR  = 2'd0,
  parameter int         READ_DELAY = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  input  logic       hold,
  output logic       read_enb,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       pkt_done,
  output logic       pkt_abort,
  output logic [5:0] pkt_len,
  output logic       addr_err,
  output logic       parity_err
);

  if (READ_DELAY < 0 || READ_DELAY > MAX_READ_DELAY) begin : g_bad_read_delay
    $error("router_dest_rx: READ_DELAY outside the soft-reset window");
  end

  localparam logic [4:0] DLY_LAST = 5'(READ_DELAY);

  rx_state_e        state_q, state_d;
  logic [4:0]       dly_cnt_q, dly_cnt_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;
  logic             rd_pend_q, rd_pend_d;

  logic [LEN_W-1:0] len_q;
  logic             hdr_addr_err_q;
  logic             byte_valid_q;
  logic [7:0]       byte_data_q;
  logic             pkt_done_q;
  logic             pkt_abort_q;
  logic [5:0]       pkt_len_q;
  logic             addr_err_q;
  logic             parity_err_q;

  logic             hdr_seen;
  logic [CNT_W-1:0] total;
  logic             flush;
  logic             capture;
  logic             cap_hdr;
  logic             cap_pay;
  logic             cap_last;
  logic             par_mismatch;

  assign hdr_seen = (cap_cnt_q != '0);
  assign total    = pkt_total(hdr_seen, len_q);

  // Flush only matters while a packet is in progress.
  assign flush = soft_reset &
                 ((state_q == WAIT) | (state_q == READ) | (state_q == DRAIN));

  // A flush in the same cycle wins over a pending capture.
  assign capture  = rd_pend_q & ~flush;
  assign cap_hdr  = capture & ~hdr_seen;
  assign cap_pay  = capture & hdr_seen & (cap_cnt_q <= CNT_W'(len_q));
  assign cap_last = capture & hdr_seen & (cap_cnt_q == CNT_W'(len_q) + CNT_W'(1));

  assign read_enb = (state_q == READ) & vld_out & ~hold & (issued_q < total);

  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    issued_d  = read_enb ? issued_q + CNT_W'(1) : issued_q;
    cap_cnt_d = capture ? cap_cnt_q + CNT_W'(1) : cap_cnt_q;
    rd_pend_d = read_enb;

    case (state_q)
      IDLE: begin
        if (vld_out) begin
          state_d   = WAIT;
          dly_cnt_d = '0;
          issued_d  = '0;
          cap_cnt_d = '0;
        end
      end
      WAIT: begin
        if (dly_cnt_q == DLY_LAST) begin
          state_d = READ;
        end else begin
          dly_cnt_d = dly_cnt_q + 5'd1;
        end
      end
      READ: begin
        // total is only trustworthy once the header has been captured.
        if (cap_last) begin
          state_d = DONE;
        end else if (hdr_seen && (issued_d == total)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cap_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d   = IDLE;
      dly_cnt_d = '0;
      issued_d  = '0;
      cap_cnt_d = '0;
      rd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      dly_cnt_q <= '0;
      issued_q  <= '0;
      cap_cnt_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      issued_q  <= issued_d;
      cap_cnt_q <= cap_cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      len_q          <= '0;
      hdr_addr_err_q <= 1'b0;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      pkt_done_q     <= 1'b0;
      pkt_abort_q    <= 1'b0;
      pkt_len_q      <= '0;
      addr_err_q     <= 1'b0;
      parity_err_q   <= 1'b0;
    end else begin
      byte_valid_q <= cap_pay;
      pkt_done_q   <= cap_last;
      pkt_abort_q  <= flush;
      if (cap_pay) begin
        byte_data_q <= data_out;
      end
      if (cap_hdr) begin
        len_q          <= data_out[HDR_LEN_MSB:HDR_LEN_LSB];
        hdr_addr_err_q <= (data_out[HDR_ADDR_MSB:HDR_ADDR_LSB] != PORT_ADDR);
      end
      // Result registers only move with pkt_done; an aborted packet leaves them.
      if (cap_last) begin
        pkt_len_q    <= len_q;
        addr_err_q   <= hdr_addr_err_q;
        parity_err_q <= par_mismatch;
      end
    end
  end

`ifdef ROUTER_DEST_PARITY_CHK_EN
  router_rx_parity u_parity (
    .clock_i    (clock),
    .resetn_i   (resetn),
    .init_i     (cap_hdr),
    .acc_i      (cap_pay),
    .data_i     (data_out),
    .mismatch_o (par_mismatch)
  );
`else
  assign par_mismatch = 1'b0;
`endif

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign pkt_done   = pkt_done_q;
  assign pkt_abort  = pkt_abort_q;
  assign pkt_len    = pkt_len_q;
  assign addr_err   = addr_err_q;
  assign parity_err = parity_err_q;

endmodule
